// File: rtl/pio_input_conditioner.sv
// Button/switch input PIO: 2-flop sync, per-bit debounce, edge capture, Avalon-MM slave, level irq.
// Pin to stable_out DEBOUNCE_CYCLES+2 cycles, edge +1 more; readdata latency 1, no backpressure.
module pio_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] stable_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, stable, stable_d;
    logic [WIDTH-1:0] edge_cap, mask;
    logic [WIDTH-1:0] rise, fall, evt, clr, wdata;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    // A change must persist DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CW-1:0] cnt;
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                cnt       <= '0;
                stable[i] <= 1'b0;
            end else if (sync2[i] == stable[i]) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                cnt       <= '0;
                stable[i] <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign evt  = (EDGE_MODE == 0) ? rise : (EDGE_MODE == 1) ? fall : (rise | fall);
    assign clr  = (write && address == 2'd1) ? wdata : '0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stable_d <= '0;
            edge_cap <= '0;
            mask     <= '0;
        end else begin
            stable_d <= stable;
            // A new edge in the same cycle as its clear survives.
            edge_cap <= (edge_cap & ~clr) | evt;
            if (write && address == 2'd2)
                mask <= wdata;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd1:    rd_mux[WIDTH-1:0] = edge_cap;
            2'd2:    rd_mux[WIDTH-1:0] = mask;
            default: rd_mux[WIDTH-1:0] = sync2;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            readdata <= '0;
        else if (read)
            readdata <= rd_mux;
    end

    assign irq        = |(edge_cap & mask);
    assign stable_out = stable;
endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench: dut0 captures rising edges, dut2 captures both edges; both debounce over 16 cycles.
module tb_pio_input_conditioner;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  pin_in = '0;
    logic [7:0]  pin_in2 = '0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata2;
    logic        irq, irq2;
    logic [7:0]  stable_out, stable_out2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rstN(rstN), .pin_in(pin_in), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata), .irq(irq),
        .stable_out(stable_out));

    pio_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_MODE(2)) dut2 (
        .clk(clk), .rstN(rstN), .pin_in(pin_in2), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata2), .irq(irq2),
        .stable_out(stable_out2));

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic test_reset;
        pin_in = 8'hFF;
        rstN = 1'b0;
        tick(3);
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0 || stable_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: readdata=%h irq=%b stable=%h, want 0/0/0", readdata, irq, stable_out);
        end
        rstN = 1'b1;
        tick(17);
        checks++;
        if (stable_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_early: stable=%h want 00", stable_out);
        end
        tick();
        checks++;
        if (stable_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_stable18: stable=%h want ff", stable_out);
        end
        tick();
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'hFF || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge: edge=%h irq=%b want ff/0", readdata, irq);
        end
        bus_write(2'd1, 32'hFF);
    endtask

    task automatic test_glitch_reject;
        pin_in = 8'h00;
        tick(20);
        checks++;
        if (stable_out !== 8'h00) begin
            errors++;
            $display("FAIL glitch_setup: stable=%h want 00", stable_out);
        end
        bus_write(2'd2, 32'hFF);
        for (int c = 0; c < 80; c++) begin
            if (c % 5 == 0) pin_in[0] = ~pin_in[0];
            tick();
            checks++;
            if (stable_out[0] !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL glitch_cycle%0d: stable0=%b irq=%b want 0/0", c, stable_out[0], irq);
            end
        end
        tick(20);
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL glitch_edge: edge=%h want 0", readdata);
        end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_step;
        pin_in = 8'h04;
        tick(2);
        bus_read(2'd3);
        checks++;
        if (readdata !== 32'h04) begin
            errors++;
            $display("FAIL step_raw: raw=%h want 04", readdata);
        end
        tick(14);
        checks++;
        if (stable_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL step_early: stable2=%b want 0", stable_out[2]);
        end
        tick();
        checks++;
        if (stable_out !== 8'h04) begin
            errors++;
            $display("FAIL step_stable18: stable=%h want 04", stable_out);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL step_edge_early: edge=%h want 0", readdata);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h04) begin
            errors++;
            $display("FAIL step_edge: edge=%h want 04", readdata);
        end
        bus_read(2'd0);
        tick(2);
        checks++;
        if (readdata !== 32'h04) begin
            errors++;
            $display("FAIL step_hold: readdata=%h want 04", readdata);
        end
    endtask

    task automatic test_irq_w1c;
        bus_write(2'd2, 32'h04);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_mask: irq=%b want 1", irq);
        end
        bus_write(2'd1, 32'h04);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c: irq=%b want 0", irq);
        end
        bus_write(2'd0, 32'h00);
        bus_read(2'd0);
        checks++;
        if (readdata !== 32'h04) begin
            errors++;
            $display("FAIL ro_write: state=%h want 04", readdata);
        end
        pin_in = 8'h00;
        tick(20);
        pin_in = 8'h04;
        tick(18);
        bus_write(2'd1, 32'h04);
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h04 || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: edge=%h irq=%b want 04/1", readdata, irq);
        end
        address = 2'd2;
        writedata = 32'h0;
        read = 1'b1;
        write = 1'b1;
        tick();
        read = 1'b0;
        write = 1'b0;
        checks++;
        if (readdata !== 32'h04 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rd_wr_same: mask=%h irq=%b want 04/0", readdata, irq);
        end
        bus_write(2'd1, 32'hFF);
    endtask

    task automatic test_both_edges;
        pin_in2 = 8'h20;
        tick(21);
        bus_read(2'd1);
        checks++;
        if (readdata2 !== 32'h20) begin
            errors++;
            $display("FAIL both_rise: edge=%h want 20", readdata2);
        end
        bus_write(2'd1, 32'h20);
        bus_read(2'd1);
        checks++;
        if (readdata2 !== 32'h0) begin
            errors++;
            $display("FAIL both_clear: edge=%h want 0", readdata2);
        end
        tick(16);
        pin_in2 = 8'h00;
        tick(20);
        bus_read(2'd1);
        checks++;
        if (readdata2 !== 32'h20 || stable_out2 !== 8'h00) begin
            errors++;
            $display("FAIL both_fall: edge=%h stable=%h want 20/00", readdata2, stable_out2);
        end
        bus_write(2'd1, 32'h20);
        pin_in2 = 8'h20;
        tick(10);
        pin_in2 = 8'h00;
        tick(30);
        bus_read(2'd1);
        checks++;
        if (readdata2 !== 32'h0 || stable_out2 !== 8'h00) begin
            errors++;
            $display("FAIL both_glitch: edge=%h stable=%h want 0/00", readdata2, stable_out2);
        end
    endtask

    task automatic test_reset_mid;
        pin_in = 8'h02;
        tick(2);
        bus_read(2'd3);
        checks++;
        if (readdata !== 32'h02) begin
            errors++;
            $display("FAIL mid_raw: raw=%h want 02", readdata);
        end
        tick(9);
        rstN = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h0 || stable_out !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: readdata=%h stable=%h irq=%b want 0", readdata, stable_out, irq);
        end
        tick(3);
        rstN = 1'b1;
        tick(17);
        checks++;
        if (stable_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_early: stable1=%b want 0", stable_out[1]);
        end
        tick();
        checks++;
        if (stable_out !== 8'h02) begin
            errors++;
            $display("FAIL mid_stable18: stable=%h want 02", stable_out);
        end
        bus_read(2'd2);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_mask: mask=%h want 0", readdata);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h02 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_edge: edge=%h irq=%b want 02/0", readdata, irq);
        end
    endtask

    initial begin
        test_reset();
        test_glitch_reject();
        test_step();
        test_irq_w1c();
        test_both_edges();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
